// File: rtl/bcd_store_ctrl_pkg.sv
// Shared definitions for the FX33 BCD store sequencer: state encodings,
// sequencing constants and the double-dabble step used by both the
// combinational converter and the iterative build.
package bcd_store_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR0  = 3'd1,
    WR1  = 3'd2,
    WR2  = 3'd3,
    CONV = 3'd4
  } state_t;

  localparam int DIGIT_COUNT = 3;
  localparam int CONV_CYCLES = 8;
  localparam int CNT_W       = $clog2(CONV_CYCLES);

  // Double-dabble working register: three BCD digit fields above the binary
  // value being shifted out of the bottom.
  typedef struct packed {
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [7:0] bin;
  } dabble_t;

  // One shift/add-3 step: any digit >= 5 gets +3 so that the following
  // left shift carries correctly into the next decade.
  function automatic dabble_t dabble_step(input dabble_t cur);
    dabble_t     adj;
    logic [19:0] vec;
    adj = cur;
    if (adj.hundreds >= 4'd5) adj.hundreds = adj.hundreds + 4'd3;
    if (adj.tens     >= 4'd5) adj.tens     = adj.tens     + 4'd3;
    if (adj.ones     >= 4'd5) adj.ones     = adj.ones     + 4'd3;
    vec = adj;
    vec = {vec[18:0], 1'b0};
    return dabble_t'(vec);
  endfunction

endpackage

// File: rtl/bcd_store_ctrl_bcd.sv
// Combinational binary-to-BCD converter for an 8-bit value
// (hundreds 0..2, tens 0..9, ones 0..9), unrolled double-dabble.
module bcd_store_ctrl_bcd
  import bcd_store_ctrl_pkg::*;
(
  input  logic [7:0] value,
  output logic [1:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  dabble_t acc;
  logic    unused_bits;

  // Unrolled conversion: all eight shift/add-3 steps in one cycle.
  always_comb begin
    // NOTE: acc is fully assigned before any conditional use, so no latch.
    acc     = '0;
    acc.bin = value;
    for (int i = 0; i < CONV_CYCLES; i++) begin
      acc = dabble_step(acc);
    end
  end

  assign hundreds = acc.hundreds[1:0];
  assign tens     = acc.tens;
  assign ones     = acc.ones;

  // hundreds never exceeds 2 and bin is fully shifted out after 8 steps.
  assign unused_bits = ^{acc.hundreds[3:2], acc.bin};

endmodule

// File: rtl/bcd_store_ctrl.sv
// FX33 sequencer: converts an 8-bit value to three BCD digits and writes
// them to base, base+1, base+2 through a req/ack RAM port.
// Build option BCD_ITERATIVE_EN: replaces the combinational converter with
// an inline 8-cycle double-dabble shifter (state CONV).
module bcd_store_ctrl
  import bcd_store_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        value,
  input  logic [ADDR_W-1:0] addr_base,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack
);

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [3:0]        tens_q;
  logic [3:0]        ones_q;
  logic              accept;

  assign accept = start && (state == IDLE);
  assign busy   = (state != IDLE);

`ifdef BCD_ITERATIVE_EN
  dabble_t           shreg;
  dabble_t           shreg_next;
  logic [CNT_W-1:0]  conv_cnt;
  logic              conv_last;
  logic              unused_bits;

  assign shreg_next  = dabble_step(shreg);
  assign conv_last   = (conv_cnt == CNT_W'(CONV_CYCLES - 1));
  // hundreds never exceeds 2 and bin is fully shifted out after 8 steps.
  assign unused_bits = ^{shreg_next.hundreds[3:2], shreg_next.bin};
`else
  logic [1:0] bcd_hundreds;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;

  bcd_store_ctrl_bcd u_bcd (
    .value    (value),
    .hundreds (bcd_hundreds),
    .tens     (bcd_tens),
    .ones     (bcd_ones)
  );
`endif

  // Sequencer: state plus registered handshake outputs, held until acked.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state     <= IDLE;
      done      <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef BCD_ITERATIVE_EN
      conv_cnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
`ifdef BCD_ITERATIVE_EN
            state    <= CONV;
            conv_cnt <= '0;
`else
            state     <= WR0;
            mem_req   <= 1'b1;
            mem_addr  <= addr_base;
            mem_wdata <= {6'b0, bcd_hundreds};
`endif
          end
        end
`ifdef BCD_ITERATIVE_EN
        CONV: begin
          if (conv_last) begin
            state     <= WR0;
            mem_req   <= 1'b1;
            mem_addr  <= base;
            mem_wdata <= {6'b0, shreg_next.hundreds[1:0]};
          end else begin
            conv_cnt <= conv_cnt + 1'b1;
          end
        end
`endif
        WR0: begin
          if (mem_ack) begin
            state     <= WR1;
            mem_addr  <= base + ADDR_W'(1);
            mem_wdata <= {4'b0, tens_q};
          end
        end
        WR1: begin
          if (mem_ack) begin
            state     <= WR2;
            mem_addr  <= base + ADDR_W'(DIGIT_COUNT - 1);
            mem_wdata <= {4'b0, ones_q};
          end
        end
        WR2: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Operand capture: base address and the digits still to be written.
  always_ff @(posedge clk) begin
    // NOTE: no reset here; these are always loaded before they are read.
    if (accept) begin
      base <= addr_base;
`ifdef BCD_ITERATIVE_EN
      shreg <= '{hundreds: 4'd0, tens: 4'd0, ones: 4'd0, bin: value};
`else
      tens_q <= bcd_tens;
      ones_q <= bcd_ones;
`endif
    end
`ifdef BCD_ITERATIVE_EN
    else if (state == CONV) begin
      shreg <= shreg_next;
      if (conv_last) begin
        tens_q <= shreg_next.tens;
        ones_q <= shreg_next.ones;
      end
    end
`endif
  end

endmodule

// File: doc/bcd_store_ctrl.md
Name: bcd_store_ctrl

Overview:
Sequencer for the CHIP-8 FX33 instruction (store BCD of VX at I, I+1, I+2). Accepts an 8-bit value and a 12-bit base address from the CPU core and converts the value to hundreds/tens/ones digits using the existing bcd datapath. It then issues three byte writes to the shared RAM port through a req/ack handshake, because the memory arbiter may stall it.

Parameters:
ADDR_W, 12, memory address width; addresses wrap modulo 2^ADDR_W

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-high; sampled on clk
start  in  1  one-cycle request; honoured only when busy=0
value  in  8  VX value, sampled on accepted start
addr_base  in  ADDR_W  I register, sampled on accepted start
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse after third write acknowledged
mem_req  out  1  write request to arbiter
mem_addr  out  ADDR_W  write address, stable while mem_req=1
mem_wdata  out  8  write data, stable while mem_req=1
mem_ack  in  1  arbiter accepts current write in this cycle

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, mem_req=0, mem_addr=0, mem_wdata=0. Reset overrides everything, including a mid-operation abort: mem_req drops the next cycle, and no done is issued.
- States: IDLE, CONV (feature only), WR0, WR1, WR2.
- IDLE:
  - On start=1, latch value and addr_base.
  - Without the feature, also latch the bcd digits, then go to WR0.
- WR0: mem_req=1, mem_addr=base, mem_wdata={6'b0,hundreds}. On mem_ack go to WR1.
- WR1: addr=base+1, data={4'b0,tens}. On mem_ack go to WR2.
- WR2: addr=base+2, data={4'b0,ones}. On mem_ack go to IDLE and set done=1 for exactly one cycle.
- Address arithmetic is ADDR_W bits and wraps: base 0xFFE gives 0xFFE, 0xFFF, 0x000.
- Handshake:
  - mem_req, mem_addr and mem_wdata are registered and held unchanged until a cycle with mem_ack=1.
  - Each acked cycle completes exactly one write.
  - mem_ack while mem_req=0 is ignored.
- Latency with mem_ack tied high: start at cycle 0, writes occupy cycles 1, 2, 3, done at cycle 4. Each stall cycle adds one.
- start while busy=1 is ignored (no queuing).
- start in the done cycle is accepted, because state is already IDLE; done and the new acceptance coexist.
- Digit invariants: hundreds<=2, tens<=9, ones<=9, and 100*h+10*t+o == value.

Optional Feature:
- Macro: BCD_ITERATIVE_EN.
- Defined:
  - The combinational bcd instance is replaced by an internal double-dabble shifter: 8 shift/add-3 cycles in state CONV, entered from IDLE on start.
  - WR0 begins after CONV completes: writes at cycles 9, 10, 11, done at 12 with ack tied high.
  - Reset in CONV returns to IDLE.
- Undefined: bcd is instantiated combinationally, with the latency given above.
- Port list is identical in both builds.

Decomposition:
- Shared include header holds:
  - state encodings (IDLE=0, WR0=1, WR1=2, WR2=3, CONV=4) as localparams;
  - DIGIT_COUNT=3 and CONV_CYCLES=8.
- Natural sub-module: the existing bcd (value -> hundreds[1:0], tens[3:0], ones[3:0]), instantiated unchanged in the non-feature build.
- The shifter stays inline in the controller; no second sub-module.

Test Plan:
- value=255, base=0x300, ack tied high -> writes (0x300,2), (0x301,5), (0x302,5) in cycles 1-3; done in cycle 4; busy high in cycles 1-3.
- value=0 and value=100 at base 0x000 -> writes 0,0,0 and 1,0,0. Full sweep 0..255 with a bench memory model checks the digit invariants and 100h+10t+o==value.
- value=42, base=0xFFE -> addresses 0xFFE, 0xFFF, 0x000 with data 0, 4, 2.
- value=137, mem_ack low for 3 cycles on each write -> mem_addr/mem_wdata stable during the stalls; exactly 3 writes; done 1 cycle after the final ack (cycle 13).
- start pulsed during WR1 with value=9 -> ignored, only the first operation's writes occur. start asserted in the done cycle with value=9 -> new sequence 0, 0, 9 begins the next cycle.
- reset asserted during WR1 -> mem_req=0 and busy=0 the next cycle; no done pulse; the next start runs normally.
- Repeat the suite with BCD_ITERATIVE_EN: 255 at base 0x300 -> writes in cycles 9-11, done at cycle 12.
